// File: rtl/heap_pkg.sv
// Shared heap definitions: default widths/sizes and the move-engine state encoding.
// No logic; imported by the move engine and its interface.
// No flow control here; pure type and constant definitions.
package heap_pkg;

    localparam int DefMemoryElementWidth = 12;
    localparam int DefNArea              = 16;
    localparam int DefAddressWidth       = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } move_state_t;

endpackage

// File: rtl/heap_move_long_if.sv
// Command, status, heap request and array-size update signals of the move engine.
// Latency/flow: start is a level request sampled only when the engine is idle;
// heap read data returns one cycle after the read request, no stall path.
interface heap_move_long_if
    import heap_pkg::*;
#(
    parameter int MemoryElementWidth = DefMemoryElementWidth,
    parameter int AddressWidth       = DefAddressWidth
);
    logic                          start;
    logic [MemoryElementWidth-1:0] sourceArray;
    logic [MemoryElementWidth-1:0] sourceOffset;
    logic [MemoryElementWidth-1:0] targetArray;
    logic [MemoryElementWidth-1:0] targetOffset;
    logic [MemoryElementWidth-1:0] length;
    logic                          busy;
    logic                          done;
    logic                          error;
    logic                          heapEnable;
    logic                          heapWrite;
    logic [AddressWidth-1:0]       heapAddress;
    logic [MemoryElementWidth-1:0] heapIn;
    logic [MemoryElementWidth-1:0] heapOut;
    logic                          sizeWrite;
    logic [MemoryElementWidth-1:0] sizeArray;
    logic [MemoryElementWidth-1:0] sizeValue;

    // master = the move engine, slave = requester plus heap memory
    modport master (
        input  start, sourceArray, sourceOffset, targetArray, targetOffset, length, heapOut,
        output busy, done, error, heapEnable, heapWrite, heapAddress, heapIn,
               sizeWrite, sizeArray, sizeValue
    );
    modport slave (
        output start, sourceArray, sourceOffset, targetArray, targetOffset, length, heapOut,
        input  busy, done, error, heapEnable, heapWrite, heapAddress, heapIn,
               sizeWrite, sizeArray, sizeValue
    );
endinterface

// File: rtl/heap_move_long.sv
// Heap array move (memmove) engine: copies length elements between array areas.
// Latency: 3 cycles per element, start-to-done 3*length+2 (2 when length is 0).
// No backpressure: start is ignored while busy; the heap must answer reads next cycle.
module heap_move_long
    import heap_pkg::*;
#(
    parameter int MemoryElementWidth = DefMemoryElementWidth,
    parameter int NArea              = DefNArea,
    parameter int AddressWidth       = DefAddressWidth
) (
    input  logic              clock,
    input  logic              reset,
    heap_move_long_if.master  bus
);
    localparam int W = MemoryElementWidth;

    move_state_t   state;
    logic [W-1:0]  src_array, src_offset, tgt_array, tgt_offset, len;
    logic [W-1:0]  idx, remaining, data;
    logic          descending;

    logic [W:0]    src_end, tgt_end;
    logic          out_of_area, is_desc;
    logic [W-1:0]  first_idx, next_idx;

    function automatic logic [AddressWidth-1:0] elem_addr(input logic [W-1:0] arr,
                                                          input logic [W-1:0] off,
                                                          input logic [W-1:0] i);
        return AddressWidth'(arr * NArea) + AddressWidth'(off) + AddressWidth'(i);
    endfunction

    // Bounds sums are one bit wider so an oversized length cannot wrap into range
    assign src_end     = {1'b0, src_offset} + {1'b0, len};
    assign tgt_end     = {1'b0, tgt_offset} + {1'b0, len};
    assign out_of_area = (src_end > (W+1)'(NArea)) || (tgt_end > (W+1)'(NArea));
    assign is_desc     = (src_array == tgt_array) && (tgt_offset > src_offset);
    assign first_idx   = is_desc ? len - W'(1) : '0;
    assign next_idx    = descending ? idx - W'(1) : idx + W'(1);
    assign bus.heapIn  = data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            src_array       <= '0;
            src_offset      <= '0;
            tgt_array       <= '0;
            tgt_offset      <= '0;
            len             <= '0;
            idx             <= '0;
            remaining       <= '0;
            data            <= '0;
            descending      <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
            bus.heapEnable  <= 1'b0;
            bus.heapWrite   <= 1'b0;
            bus.heapAddress <= '0;
            bus.sizeWrite   <= 1'b0;
            bus.sizeArray   <= '0;
            bus.sizeValue   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done      <= 1'b0;
                    bus.error     <= 1'b0;
                    bus.sizeWrite <= 1'b0;
                    if (bus.start) begin
                        src_array  <= bus.sourceArray;
                        src_offset <= bus.sourceOffset;
                        tgt_array  <= bus.targetArray;
                        tgt_offset <= bus.targetOffset;
                        len        <= bus.length;
                        bus.busy   <= 1'b1;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (out_of_area) begin
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end else if (len == '0) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        descending      <= is_desc;
                        idx             <= first_idx;
                        remaining       <= len;
                        bus.heapEnable  <= 1'b1;
                        bus.heapWrite   <= 1'b0;
                        bus.heapAddress <= elem_addr(src_array, src_offset, first_idx);
                        state           <= READ;
                    end
                end
                READ: begin
                    bus.heapEnable <= 1'b0;
                    state          <= CAPTURE;
                end
                CAPTURE: begin
                    data            <= bus.heapOut;
                    bus.heapEnable  <= 1'b1;
                    bus.heapWrite   <= 1'b1;
                    bus.heapAddress <= elem_addr(tgt_array, tgt_offset, idx);
                    state           <= WRITE;
                end
                WRITE: begin
                    bus.heapWrite <= 1'b0;
                    if (remaining == W'(1)) begin
                        bus.heapEnable <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.sizeWrite  <= 1'b1;
                        bus.sizeArray  <= tgt_array;
                        bus.sizeValue  <= tgt_offset + len;
                        state          <= DONE;
                    end else begin
                        idx             <= next_idx;
                        remaining       <= remaining - W'(1);
                        bus.heapEnable  <= 1'b1;
                        bus.heapAddress <= elem_addr(src_array, src_offset, next_idx);
                        state           <= READ;
                    end
                end
                DONE: begin
                    bus.done      <= 1'b0;
                    bus.sizeWrite <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_heap_move_long.sv
// Bench for heap_move_long: heap memory model behind the request port, cycle
// schedule and memmove image derived from the move rules, directed and random moves.
module tb_heap_move_long;
    localparam int W  = 12;
    localparam int N  = 16;
    localparam int AW = 12;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    heap_move_long_if #(.MemoryElementWidth(W), .AddressWidth(AW)) bus ();

    heap_move_long #(.MemoryElementWidth(W), .NArea(N), .AddressWidth(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Heap memory: one-cycle read latency, preloaded with mem[a] = a
    logic [W-1:0] mem [0:4095];
    logic         mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int a = 0; a < 4096; a++) mem[a] <= W'(a);
            mem_ready <= 1'b1;
        end else if (bus.heapEnable) begin
            if (bus.heapWrite) mem[bus.heapAddress] <= bus.heapIn;
            else               bus.heapOut <= mem[bus.heapAddress];
        end
    end

    logic [W-1:0] model_mem [0:4095];
    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] pack(input bit bsy, input bit dn, input bit er,
                                         input bit en, input bit wr, input logic [11:0] ad,
                                         input logic [11:0] din, input bit sw,
                                         input logic [11:0] sa, input logic [11:0] sv);
        return {10'b0, bsy, dn, er, en, wr, en ? ad : 12'h0, (en && wr) ? din : 12'h0,
                sw, sw ? sa : 12'h0, sw ? sv : 12'h0};
    endfunction

    function automatic logic [63:0] dut_vec();
        return pack(bus.busy, bus.done, bus.error, bus.heapEnable, bus.heapWrite,
                    bus.heapAddress, bus.heapIn, bus.sizeWrite, bus.sizeArray, bus.sizeValue);
    endfunction

    function automatic logic [63:0] raw_outputs();
        return {4'b0, bus.busy, bus.done, bus.error, bus.heapEnable, bus.heapWrite,
                bus.sizeWrite, bus.heapAddress, bus.heapIn, bus.sizeArray, bus.sizeValue};
    endfunction

    task automatic check_memory(input string name);
        int diffs = 0;
        for (int a = 0; a < 4096; a++) if (mem[a] !== model_mem[a]) diffs++;
        check(name, 64'(diffs), 64'd0);
    endtask

    // Called at a falling edge; returns at the falling edge of the last checked cycle.
    task automatic run_move(input int sa, input int so, input int ta, input int to,
                            input int len, input bit hold, output int done_cycle,
                            output int err_cycle, output int first_rd,
                            output logic [11:0] sz_arr, output logic [11:0] sz_val);
        bit err  = (so + len > N) || (to + len > N);
        bit desc = (sa == ta) && (to > so);
        int last_k = err ? 3 : 3 * len + 3;
        logic [W-1:0] srcv [0:15];
        done_cycle = -1; err_cycle = -1; first_rd = -1; sz_arr = '0; sz_val = '0;
        for (int j = 0; j < 16; j++) srcv[j] = (!err && j < len) ? model_mem[sa*N + so + j] : '0;
        bus.sourceArray = W'(sa); bus.sourceOffset = W'(so);
        bus.targetArray = W'(ta); bus.targetOffset = W'(to);
        bus.length = W'(len); bus.start = 1'b1;
        for (int k = 1; k <= last_k; k++) begin
            bit bsy = 0, dn = 0, er = 0, en = 0, wr = 0, sw = 0;
            int ad = 0, din = 0, sza = 0, szv = 0;
            @(negedge clock);
            if (k == 1 && !hold) bus.start = 1'b0;
            bsy = (k <= (err ? 1 : 3 * len + 2));
            if (err) er = (k == 2);
            else if (k >= 2 && k <= 3 * len + 1) begin
                int j  = (k - 2) / 3;
                int ph = (k - 2) % 3;
                int i  = desc ? len - 1 - j : j;
                if (ph == 0) begin en = 1; ad = sa * N + so + i; end
                if (ph == 2) begin en = 1; wr = 1; ad = ta * N + to + i; din = int'(srcv[i]); end
            end else if (k == 3 * len + 2) begin
                dn = 1;
                if (len > 0) begin sw = 1; sza = ta; szv = to + len; end
            end
            if (bus.done) done_cycle = k;
            if (bus.error) err_cycle = k;
            if (bus.sizeWrite) begin sz_arr = bus.sizeArray; sz_val = bus.sizeValue; end
            if (first_rd < 0 && bus.heapEnable && !bus.heapWrite) first_rd = int'(bus.heapAddress);
            check($sformatf("outputs cycle %0d of move %0d.%0d->%0d.%0d len %0d", k, sa, so, ta, to, len),
                  dut_vec(), pack(bsy, dn, er, en, wr, 12'(ad), 12'(din), sw, 12'(sza), 12'(szv)));
        end
        if (!err) for (int i = 0; i < len; i++) model_mem[ta*N + to + i] = srcv[i];
        check_memory($sformatf("memory after move len %0d", len));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dc, ec, fr;
        logic [11:0] za, zv;
        for (int a = 0; a < 4096; a++) model_mem[a] = W'(a);
        bus.start = 1'b0; bus.sourceArray = '0; bus.sourceOffset = '0;
        bus.targetArray = '0; bus.targetOffset = '0; bus.length = '0;
        repeat (3) @(negedge clock);
        check("reset outputs", raw_outputs(), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("idle after reset", raw_outputs(), 64'd0);

        // Array 1 <- array 0 elements 0..2 at offset 2
        run_move(0, 0, 1, 2, 3, 0, dc, ec, fr, za, zv);
        check("copy done cycle", 64'(dc), 64'd11);
        check("copy size update", {za, zv}, {12'd1, 12'd5});
        check("copy heap[18..20]", {mem[18], mem[19], mem[20]}, {12'd0, 12'd1, 12'd2});

        // Overlapping forward move in array 0 must copy from the top down
        run_move(0, 0, 0, 2, 4, 0, dc, ec, fr, za, zv);
        check("overlap heap[2..5]", {mem[2], mem[3], mem[4], mem[5]}, {12'd0, 12'd1, 12'd2, 12'd3});
        check("overlap first read address", 64'(fr), 64'd3);

        run_move(0, 2, 1, 0, 15, 0, dc, ec, fr, za, zv);
        check("reject error cycle", 64'(ec), 64'd2);
        check("reject no done", 64'(dc), 64'hFFFF_FFFF_FFFF_FFFF);
        check("reject no heap read", 64'(fr), 64'hFFFF_FFFF_FFFF_FFFF);

        run_move(2, 3, 3, 4, 0, 0, dc, ec, fr, za, zv);
        check("empty move done cycle", 64'(dc), 64'd2);

        // Reset during element 1 of a 3-element move from array 2 to array 3 offset 1
        bus.sourceArray = 12'd2; bus.sourceOffset = 12'd0;
        bus.targetArray = 12'd3; bus.targetOffset = 12'd1;
        bus.length = 12'd3; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        check("second element read issued", {bus.heapEnable, bus.heapWrite, bus.heapAddress}, {1'b1, 1'b0, 12'd33});
        #2 reset = 1'b0;
        #1 check("outputs under reset", raw_outputs(), 64'd0);
        check("first element written", 64'(mem[49]), 64'd32);
        check("second element untouched", 64'(mem[50]), 64'd50);
        model_mem[49] = 12'd32;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_move(2, 5, 1, 8, 5, 0, dc, ec, fr, za, zv);

        // Start held high: one move, then re-accepted only after DONE
        run_move(1, 0, 3, 10, 2, 1, dc, ec, fr, za, zv);
        check("held start single done", 64'(dc), 64'd8);
        run_move(1, 0, 3, 10, 2, 0, dc, ec, fr, za, zv);

        for (int n = 0; n < 40; n++) begin
            int len = $urandom_range(0, 9) < 2 ? $urandom_range(0, 16) : $urandom_range(0, 8);
            run_move($urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 2),
                     $urandom_range(0, 15), len, 0, dc, ec, fr, za, zv);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/heap_move_long.md
HEAP_MOVE_LONG -- requirements
Module: heap_move_long

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12: width of every heap element and operand.
REQ-002 SHALL have parameter NArea, default 16: elements per array area; array base = array*NArea.
REQ-003 SHALL have parameter AddressWidth, default 12: heap address width.
REQ-004 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset is asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: request a move; sampled only in IDLE.
REQ-007 SHALL have ports sourceArray, sourceOffset, targetArray, targetOffset, length, each input, MemoryElementWidth: move operands, captured on accepted start.
REQ-008 SHALL have port busy, output, 1: high from the accepted start until DONE is left.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port error, output, 1: one-cycle pulse on a rejected move.
REQ-011 SHALL have ports heapEnable, output, 1; heapWrite, output, 1; heapAddress, output, AddressWidth; heapIn, output, MemoryElementWidth: heap memory request port.
REQ-012 SHALL have port heapOut, input, MemoryElementWidth: read data, valid the cycle after a read request.
REQ-013 SHALL have ports sizeWrite, output, 1; sizeArray, output, MemoryElementWidth; sizeValue, output, MemoryElementWidth: array-length update for the executor.

Function
REQ-014 SHALL implement states IDLE, CHECK, READ, CAPTURE, WRITE, DONE.
REQ-015 IDLE with start=1 SHALL latch the operands, raise busy and go to CHECK; start in any other state SHALL be ignored.
REQ-016 CHECK SHALL pulse error and return to IDLE, with no heap access, when sourceOffset+length > NArea or targetOffset+length > NArea (sums computed one bit wider, no wrap).
REQ-017 CHECK SHALL go directly to DONE when length=0, with no heap access and no sizeWrite.
REQ-018 CHECK SHALL select descending copy when sourceArray=targetArray and targetOffset>sourceOffset, and ascending copy otherwise (memmove semantics).
REQ-019 READ SHALL drive heapEnable=1, heapWrite=0, heapAddress=sourceArray*NArea+sourceOffset+i.
REQ-020 CAPTURE SHALL drive heapEnable=0 and latch heapOut into an internal data register.
REQ-021 WRITE SHALL drive heapEnable=1, heapWrite=1, heapAddress=targetArray*NArea+targetOffset+i and heapIn=latched data; it then advances i and goes to READ, or goes to DONE after the last element.
REQ-022 The element index i SHALL run 0..length-1 ascending or length-1..0 descending.
REQ-023 Each element SHALL take exactly 3 cycles; start-to-done latency SHALL be 3*length+2 cycles for length>0 and 2 cycles for length=0.
REQ-024 DONE SHALL pulse done for one cycle, drop busy, and return to IDLE.
REQ-025 DONE SHALL also pulse sizeWrite with sizeArray=targetArray and sizeValue=targetOffset+length when length>0; the executor applies the max with the current length.
REQ-026 heapEnable SHALL be 0 in IDLE, CHECK, CAPTURE and DONE.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, with busy, done, error, heapEnable, heapWrite and sizeWrite at 0 and heapAddress, heapIn, sizeArray, sizeValue and internal registers at 0.
REQ-028 Reset mid-move SHALL abandon the move without done or sizeWrite; already-written elements remain in memory.

Structure
REQ-029 A shared package heap_pkg SHALL hold MemoryElementWidth, NArea and AddressWidth defaults and the state enum.
REQ-030 The block SHALL contain no sub-module; the bench SHALL instantiate the existing heap memory model behind the request port.

Verification
REQ-031 Array0[0..9]=0..9, start src(0,0) tgt(1,2) len 3 -> heap[18..20]=0,1,2; done 11 cycles after start; sizeWrite with (1,5).
REQ-032 Same array 0 holding 0..9, src offset 0, tgt offset 2, len 4 -> heap[2..5]=0,1,2,3 via a descending address sequence.
REQ-033 len 15, src offset 2 -> error pulse 1 cycle after CHECK, no heapEnable, busy low again, no done.
REQ-034 len 0 -> done 2 cycles after start, no heap access, no sizeWrite.
REQ-035 reset low during the second element of a len-3 move -> all outputs 0 immediately; heap[tgt] written, heap[tgt+1] unwritten; the next start is accepted normally.
REQ-036 start held high throughout a move -> exactly one move executed; a new move is accepted only after DONE.
